// File: rtl/sel_rr_scheduler.sv
// Round-robin owner of a shared 4-to-1 selector: grants one requester at a time
// for a bounded burst and presents its data downstream with valid/ready.
module sel_rr_scheduler #(
  parameter int DW      = 8,
  parameter int BURST_W = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [3:0]           Req,
  input  logic [4*DW-1:0]      In_data,
  input  logic [BURST_W-1:0]   Burst_len,
  input  logic                 Out_ready,
  output logic                 Out_valid,
  output logic [DW-1:0]        Out_data,
  output logic [1:0]           Sel,
  output logic [3:0]           Grant,
  output logic                 Busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [BURST_W-1:0] LEN_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] LEN_ZERO = {BURST_W{1'b0}};

  state_t             state_r, state_s;
  logic [1:0]         sel_r, last_r, winner_s;
  logic [3:0]         grant_r;
  logic [BURST_W-1:0] cnt_r, len_r;
  logic [BURST_W:0]   cnt_inc_s;
  logic               owner_req_s, accept_s, last_beat_s, exit_s, start_s;

  // First set bit scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Arbitration, beat acceptance and next-state decode.
  always_comb begin
    state_s     = state_r;
    winner_s    = rr_pick(Req, last_r);
    owner_req_s = Req[sel_r];
    accept_s    = 1'b0;
    cnt_inc_s   = {1'b0, cnt_r} + {{BURST_W{1'b0}}, 1'b1};
    last_beat_s = (cnt_inc_s == {1'b0, len_r});
    exit_s      = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (Req != 4'b0000) begin
          start_s = 1'b1;
          state_s = XFER;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        accept_s = owner_req_s & Out_ready;
        exit_s   = (accept_s & last_beat_s) | ~owner_req_s;
        if (exit_s) begin
          state_s = IDLE;
        end else begin
          state_s = XFER;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, ownership and burst counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      sel_r   <= 2'd0;
      last_r  <= 2'd3;
      grant_r <= 4'b0000;
      cnt_r   <= LEN_ZERO;
      len_r   <= LEN_ONE;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        sel_r   <= winner_s;
        grant_r <= 4'b0001 << winner_s;
        len_r   <= (Burst_len == LEN_ZERO) ? LEN_ONE : Burst_len;
        cnt_r   <= LEN_ZERO;
      end else if (exit_s) begin
        last_r  <= sel_r;
        grant_r <= 4'b0000;
        cnt_r   <= LEN_ZERO;
      end else if (accept_s) begin
        cnt_r   <= cnt_inc_s[BURST_W-1:0];
      end
    end
  end

  // Downstream data path, driven from the registered selector code.
  always_comb begin
    Out_data = {DW{1'b0}};
    if (state_r == XFER) begin
      case (sel_r)
        2'd0:    Out_data = In_data[0*DW +: DW];
        2'd1:    Out_data = In_data[1*DW +: DW];
        2'd2:    Out_data = In_data[2*DW +: DW];
        2'd3:    Out_data = In_data[3*DW +: DW];
        default: Out_data = {DW{1'b0}};
      endcase
    end else begin
      Out_data = {DW{1'b0}};
    end
  end

  assign Out_valid = (state_r == XFER) & owner_req_s;
  assign Busy      = (state_r == XFER);
  assign Sel       = sel_r;
  assign Grant     = grant_r;

endmodule
